fft_rotr_addr_gen: RTL and testbench
====================================

FFT_ROTR_ADDR_GEN -- requirements
Module: fft_rotr_addr_gen

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, meaning the number of rotate passes per run (legal 1..5).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clr, input, 1 bit: synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-005 SHALL have port out_ready, input, 1 bit: consumer accepts addr this cycle.
REQ-006 SHALL have port out_valid, output, 1 bit: addr/stage valid.
REQ-007 SHALL have port addr, output, 5 bits: read address (rotated index).
REQ-008 SHALL have port stage, output, 3 bits: pass number of the current addr.
REQ-009 SHALL have port busy, output, 1 bit: run in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle end-of-run pulse.

Function
REQ-011 SHALL implement the states IDLE and RUN, held in registered state only.
REQ-012 SHALL define a transfer as a cycle with out_valid=1 and out_ready=1.
REQ-013 SHALL, in IDLE with start=1 at edge N, enter RUN with stage=0, index=0, out_valid=1 and busy=1 visible after edge N (1-cycle latency).
REQ-014 SHALL drive, in RUN, addr = index rotated right by stage bits (5-bit circular; stage 0 = identity, stage 4 = rotate right by 4), registered.
REQ-015 SHALL hold addr, stage and out_valid stable while out_valid=1 and out_ready=0 (no drop, no skip).
REQ-016 SHALL, on a transfer, advance index by 1; index wraps 31 -> 0 and increments stage in the same edge.
REQ-017 SHALL, on the transfer of index 31 in the last pass, go to IDLE with out_valid=0, busy=0 and done=1 for exactly the next cycle.
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL accept start in the cycle where done=1, because the state is already IDLE.
REQ-020 SHALL emit exactly 32*passes transfers per run, with passes=NUM_STAGES (or NUM_STAGES+1 per REQ-027), and no gaps other than out_ready stalls.
REQ-021 SHALL keep addr=0 and stage=0 whenever out_valid=0.

Reset
REQ-022 SHALL, with clr=1 at an edge, force IDLE with out_valid=0, addr=0, stage=0, busy=0, done=0 and index=0, regardless of state.
REQ-023 SHALL give clr priority over start and over transfers in the same cycle.
REQ-024 SHALL, when clr aborts a run mid-operation, produce no done pulse.
REQ-025 SHALL bring all outputs to the REQ-022 values at time 0 before the first clock.

Configuration
REQ-026 SHALL use the macro FFT_ROTR_BITREV_EN to compile the bit-reverse pass in or out.
REQ-027 SHALL, with FFT_ROTR_BITREV_EN defined, append one extra pass with stage=NUM_STAGES whose addr is the 5-bit bit-reversal of index (addr[k]=index[4-k]).
REQ-028 SHALL, with FFT_ROTR_BITREV_EN undefined, generate no extra pass; the last pass is stage NUM_STAGES-1.

Verification
REQ-029 SHALL test: clr=1 for 2 cycles, then start pulse with out_ready=1 -> first transfer stage=0 addr=0; stage 0 addr sequence 0,1,2,...,31.
REQ-030 SHALL test: continuous out_ready=1 -> stage 1 index 1 gives addr=16; stage 2 index 3 gives addr=24; stage 4 index 1 gives addr=2.
REQ-031 SHALL test: out_ready=0 for 4 cycles at stage 1 index 5 -> addr=18 held 4 cycles; next transfer is index 6 (addr=3).
REQ-032 SHALL test: full run with macro undefined -> 160 transfers, done=1 one cycle after last transfer (stage=4, addr=31), busy=0 in the same cycle.
REQ-033 SHALL test: macro defined -> 192 transfers; in stage 5, index 1 gives addr=16 and index 6 gives addr=12.
REQ-034 SHALL test: clr=1 at stage 2 index 10 -> next cycle out_valid=0, busy=0, addr=0, and no done pulse; start during busy -> no restart and sequence unchanged.

Source files
------------

// File: rtl/fft_rotr_addr_gen.sv
// Read-address generator for FFT rotate passes: each pass sweeps index 0..31 and emits it
// rotated right by the pass number. Define FFT_ROTR_BITREV_EN to append a bit-reversal pass.
module fft_rotr_addr_gen #(
    parameter int unsigned NUM_STAGES = 5
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [4:0] addr,
    output logic [2:0] stage,
    output logic       busy,
    output logic       done
);

`ifdef FFT_ROTR_BITREV_EN
    localparam int unsigned LastStage = NUM_STAGES;
`else
    localparam int unsigned LastStage = NUM_STAGES - 1;
`endif
    localparam logic [2:0] LastStageW = 3'(LastStage);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    // Power-up values keep every output at its reset value before the first edge.
    state_e     state_q = StIdle;
    logic [4:0] idx_q   = '0;
    logic [2:0] stage_q = '0;
    logic [4:0] addr_q  = '0;
    logic       valid_q = 1'b0;
    logic       done_q  = 1'b0;

    state_e     state_d;
    logic [4:0] idx_d;
    logic [2:0] stage_d;
    logic [4:0] addr_d;
    logic       valid_d;
    logic       done_d;

    function automatic logic [4:0] map_addr(input logic [4:0] idx, input logic [2:0] stg);
        logic [9:0] dbl;
        logic [4:0] res;
        dbl = {idx, idx} >> stg;
        res = dbl[4:0];
`ifdef FFT_ROTR_BITREV_EN
        if (stg == LastStageW) begin
            for (int k = 0; k < 5; k++) begin
                res[k] = idx[4-k];
            end
        end
`endif
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    idx_d   = '0;
                    stage_d = '0;
                end
            end
            StRun: begin
                if (out_ready) begin
                    if (idx_q == 5'd31) begin
                        idx_d = '0;
                        if (stage_q == LastStageW) begin
                            state_d = StIdle;
                            stage_d = '0;
                            done_d  = 1'b1;
                        end else begin
                            stage_d = stage_q + 3'd1;
                        end
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        valid_d = (state_d == StRun);
        // Address is computed from the next index so it is registered alongside it.
        addr_d  = valid_d ? map_addr(idx_d, stage_d) : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            idx_q   <= '0;
            stage_q <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign out_valid = valid_q;
    assign addr      = addr_q;
    assign stage     = stage_q;
    assign busy      = (state_q == StRun);
    assign done      = done_q;

endmodule

// File: tb/tb_fft_rotr_addr_gen.sv
// Directed self-checking bench for fft_rotr_addr_gen; expectations follow FFT_ROTR_BITREV_EN.
module tb_fft_rotr_addr_gen;

    localparam int NS = 5;
`ifdef FFT_ROTR_BITREV_EN
    localparam int PASSES = NS + 1;
`else
    localparam int PASSES = NS;
`endif
    localparam int EXP = 32 * PASSES;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [4:0] addr;
    logic [2:0] stage;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [4:0] ga [192];
    logic [2:0] gs [192];

    fft_rotr_addr_gen #(
        .NUM_STAGES(NS)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .addr     (addr),
        .stage    (stage),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Independent reference: rotate via doubled word, or bit-reverse for the extra pass.
    function automatic logic [4:0] exp_addr(input int k);
        int         s;
        logic [4:0] iv;
        logic [9:0] d;
        logic [4:0] r;
        s  = k / 32;
        iv = 5'(k % 32);
        if (s >= NS) begin
            for (int b = 0; b < 5; b++) r[b] = iv[4-b];
        end else begin
            d = {iv, iv} >> s;
            r = d[4:0];
        end
        return r;
    endfunction

    task automatic test_reset;
        #1;
        checks++;
        if ({out_valid, addr, stage, busy, done} !== 11'b0) begin
            errors++;
            $display("FAIL reset_time0: got v=%b a=%0d s=%0d b=%b d=%b, want all 0",
                     out_valid, addr, stage, busy, done);
        end
        clr = 1'b1;
        step;
        step;
        checks++;
        if ({out_valid, addr, stage, busy, done} !== 11'b0) begin
            errors++;
            $display("FAIL reset_clr: got v=%b a=%0d s=%0d b=%b d=%b, want all 0",
                     out_valid, addr, stage, busy, done);
        end
        clr = 1'b0;
    endtask

    task automatic test_full_run;
        int n, gaps, early_done, cyc;
        out_ready = 1'b1;
        start = 1'b1;
        step;
        start = 1'b0;
        checks++;
        if (!(out_valid === 1'b1 && busy === 1'b1 && stage === 3'd0 && addr === 5'd0)) begin
            errors++;
            $display("FAIL first_xfer: got v=%b b=%b s=%0d a=%0d, want v=1 b=1 s=0 a=0",
                     out_valid, busy, stage, addr);
        end
        n = 0; gaps = 0; early_done = 0; cyc = 0;
        while (n < EXP && cyc < EXP + 100) begin
            if (done) early_done++;
            if (out_valid) begin
                ga[n] = addr;
                gs[n] = stage;
                n++;
            end else begin
                gaps++;
            end
            step;
            cyc++;
        end
        checks++;
        if (n !== EXP) begin
            errors++;
            $display("FAIL xfer_count: got %0d, want %0d", n, EXP);
        end
        checks++;
        if (gaps !== 0 || early_done !== 0) begin
            errors++;
            $display("FAIL run_gaps: got gaps=%0d early_done=%0d, want 0 0", gaps, early_done);
        end
        checks++;
        if (!(done === 1'b1 && busy === 1'b0 && out_valid === 1'b0 && addr === 5'd0
              && stage === 3'd0)) begin
            errors++;
            $display("FAIL done_pulse: got d=%b b=%b v=%b a=%0d s=%0d, want d=1 b=0 v=0 a=0 s=0",
                     done, busy, out_valid, addr, stage);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (ga[i] !== 5'(i)) begin
                errors++;
                $display("FAIL stage0_seq[%0d]: got %0d, want %0d", i, ga[i], i);
            end
        end
        for (int k = 32; k < n; k++) begin
            checks++;
            if (ga[k] !== exp_addr(k) || gs[k] !== 3'(k / 32)) begin
                errors++;
                $display("FAIL xfer[%0d]: got s=%0d a=%0d, want s=%0d a=%0d",
                         k, gs[k], ga[k], k / 32, exp_addr(k));
            end
        end
        checks++;
        if (ga[33] !== 5'd16 || ga[67] !== 5'd24 || ga[129] !== 5'd2 || gs[129] !== 3'd4) begin
            errors++;
            $display("FAIL spot_rot: got %0d %0d %0d s=%0d, want 16 24 2 s=4",
                     ga[33], ga[67], ga[129], gs[129]);
        end
`ifdef FFT_ROTR_BITREV_EN
        checks++;
        if (ga[161] !== 5'd16 || ga[166] !== 5'd12 || gs[161] !== 3'd5
            || ga[191] !== 5'd31 || gs[191] !== 3'd5) begin
            errors++;
            $display("FAIL spot_bitrev: got %0d %0d s=%0d last=%0d/%0d, want 16 12 s=5 last=31/5",
                     ga[161], ga[166], gs[161], ga[191], gs[191]);
        end
`else
        checks++;
        if (ga[159] !== 5'd31 || gs[159] !== 3'd4) begin
            errors++;
            $display("FAIL last_xfer: got a=%0d s=%0d, want a=31 s=4", ga[159], gs[159]);
        end
`endif
    endtask

    // Entered in the done cycle left by test_full_run.
    task automatic test_back_to_back;
        start = 1'b1;
        step;
        start = 1'b0;
        checks++;
        if (!(busy === 1'b1 && out_valid === 1'b1 && stage === 3'd0 && addr === 5'd0
              && done === 1'b0)) begin
            errors++;
            $display("FAIL back_to_back: got b=%b v=%b s=%0d a=%0d d=%b, want 1 1 0 0 0",
                     busy, out_valid, stage, addr, done);
        end
        clr = 1'b1;
        step;
        clr = 1'b0;
    endtask

    task automatic test_stall;
        out_ready = 1'b1;
        start = 1'b1;
        step;
        start = 1'b0;
        repeat (37) step;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (!(out_valid === 1'b1 && stage === 3'd1 && addr === 5'd18)) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b s=%0d a=%0d, want v=1 s=1 a=18",
                         c, out_valid, stage, addr);
            end
            step;
        end
        out_ready = 1'b1;
        step;
        checks++;
        if (!(out_valid === 1'b1 && stage === 3'd1 && addr === 5'd3)) begin
            errors++;
            $display("FAIL stall_resume: got v=%b s=%0d a=%0d, want v=1 s=1 a=3",
                     out_valid, stage, addr);
        end
        clr = 1'b1;
        step;
        clr = 1'b0;
    endtask

    task automatic test_clr_abort;
        out_ready = 1'b1;
        start = 1'b1;
        step;
        repeat (5) step;
        start = 1'b0;
        repeat (69) step;
        checks++;
        if (!(out_valid === 1'b1 && stage === 3'd2 && addr === 5'd18)) begin
            errors++;
            $display("FAIL start_while_busy: got v=%b s=%0d a=%0d, want v=1 s=2 a=18",
                     out_valid, stage, addr);
        end
        clr = 1'b1;
        step;
        clr = 1'b0;
        checks++;
        if ({out_valid, addr, stage, busy, done} !== 11'b0) begin
            errors++;
            $display("FAIL clr_abort: got v=%b a=%0d s=%0d b=%b d=%b, want all 0",
                     out_valid, addr, stage, busy, done);
        end
        for (int c = 0; c < 3; c++) begin
            step;
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done[%0d]: got d=%b v=%b, want 0 0", c, done, out_valid);
            end
        end
        clr = 1'b1;
        start = 1'b1;
        step;
        clr = 1'b0;
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_over_start: got v=%b b=%b, want 0 0", out_valid, busy);
        end
    endtask

    initial begin
        test_reset;
        test_full_run;
        test_back_to_back;
        test_stall;
        test_clr_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
